// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing helpers, word sizing and rx state encoding
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    function automatic int byte_count(input int data_width);
        return (data_width + 7) / 8;
    endfunction

    function automatic int ext_width(input int data_width);
        return byte_count(data_width) * 8;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: input synchroniser, bit-timing FSM, line-break guard
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int UART_BPS = 115200,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       byte_drop,
    output logic       start_edge,
    output logic       rx_idle
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int HALF         = BAUD_CNT_MAX / 2;
    localparam int CW           = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_CNT_MAX - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((HALF > 0) ? HALF - 1 : 0);

    logic            rx_s1, rx_s2, rx_s3;
    rx_state_t       state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign start_edge = rx_s3 & ~rx_s2;
    assign rx_idle    = (state == IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            byte_drop  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            byte_drop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        if (!rx_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state    <= IDLE;
                            byte_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt       <= '0;
                        shift[bit_cnt] <= rx_s2;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s2) begin
                            state      <= IDLE;
                            rx_byte    <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            state     <= BREAK;
                            byte_err  <= 1'b1;
                            byte_drop <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // a held-low line must go high for a full bit before a new start is accepted
                    if (!rx_s2) begin
                        baud_cnt <= '0;
                    end else if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_pump.sv
// rtl/uart_rx_pump.sv - assembles received UART bytes (byte 0 = bits [7:0]) into one DATA_WIDTH word
module uart_rx_pump
    import uart_pkg::*;
#(
    parameter int UART_BPS     = 115200,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DATA_WIDTH   = 120,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] po_data,
    output logic                  po_flag,
    output logic                  frame_err,
    output logic                  rx_timeout
);

    localparam int BYTE_COUNT    = byte_count(DATA_WIDTH);
    localparam int EXT_WIDTH     = ext_width(DATA_WIDTH);
    localparam int TIMEOUT_LIMIT = TIMEOUT_BITS * baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int BCW           = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;
    localparam int TCW           = $clog2(TIMEOUT_LIMIT + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTE_COUNT - 1);
    localparam logic [TCW-1:0] IDLE_LAST = TCW'(TIMEOUT_LIMIT - 1);

    logic [7:0]           rx_byte;
    logic                 byte_valid, byte_err, byte_drop, start_edge, rx_idle;
    logic [EXT_WIDTH-1:0] word_buf, word_next;
    logic [BCW-1:0]       byte_cnt;
    logic [TCW-1:0]       idle_cnt;
    logic                 timeout_hit;

    uart_rx_byte #(
        .UART_BPS (UART_BPS),
        .CLK_FREQ (CLK_FREQ)
    ) u_rx_byte (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .byte_err   (byte_err),
        .byte_drop  (byte_drop),
        .start_edge (start_edge),
        .rx_idle    (rx_idle)
    );

    always_comb begin
        word_next = word_buf;
        word_next[byte_cnt*8 +: 8] = rx_byte;
    end

    // a start edge in the expiry cycle wins over the timeout
    assign timeout_hit = rx_idle && (byte_cnt != '0) && !start_edge && (idle_cnt == IDLE_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            po_data    <= '0;
            po_flag    <= 1'b0;
            frame_err  <= 1'b0;
            rx_timeout <= 1'b0;
            word_buf   <= '0;
            byte_cnt   <= '0;
            idle_cnt   <= '0;
        end else begin
            po_flag    <= 1'b0;
            frame_err  <= byte_err;
            rx_timeout <= 1'b0;
            if (byte_valid) begin
                word_buf <= word_next;
                if (byte_cnt == LAST_BYTE) begin
                    po_data  <= word_next[DATA_WIDTH-1:0];
                    po_flag  <= 1'b1;
                    byte_cnt <= '0;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (byte_drop) begin
                byte_cnt <= '0;
            end else if (timeout_hit) begin
                byte_cnt   <= '0;
                rx_timeout <= 1'b1;
            end

            if ((byte_cnt == '0) || !rx_idle || start_edge || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_pump.sv
// tb/tb_uart_rx_pump.sv - randomized self-checking bench for uart_rx_pump against a byte-queue model
module tb_uart_rx_pump;

    localparam int CLK_FREQ = 50_000_000;
    localparam int UART_BPS = 5_000_000;
    localparam int BIT      = CLK_FREQ / UART_BPS;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        rx        = 1'b1;
    logic [15:0] po_data16;
    logic [11:0] po_data12;
    logic        po_flag16, frame_err16, rx_timeout16;
    logic        po_flag12, frame_err12, rx_timeout12;

    always #5 sys_clk = ~sys_clk;

    uart_rx_pump #(
        .UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .DATA_WIDTH(16), .TIMEOUT_BITS(20)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx),
        .po_data(po_data16), .po_flag(po_flag16),
        .frame_err(frame_err16), .rx_timeout(rx_timeout16)
    );

    uart_rx_pump #(
        .UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .DATA_WIDTH(12), .TIMEOUT_BITS(20)
    ) dut12 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx),
        .po_data(po_data12), .po_flag(po_flag12),
        .frame_err(frame_err12), .rx_timeout(rx_timeout12)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int flag16_cnt = 0, err16_cnt = 0, to16_cnt = 0;
    int flag12_cnt = 0, err12_cnt = 0, to12_cnt = 0;

    always @(negedge sys_clk) begin
        if (po_flag16)    flag16_cnt++;
        if (frame_err16)  err16_cnt++;
        if (rx_timeout16) to16_cnt++;
        if (po_flag12)    flag12_cnt++;
        if (frame_err12)  err12_cnt++;
        if (rx_timeout12) to12_cnt++;
    end

    logic [7:0]  q[$];
    logic [15:0] exp_word = '0;
    int          exp_flags = 0, exp_errs = 0, exp_tos = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        q.push_back(b);
        if (q.size() == 2) begin
            exp_word = {q[1], q[0]};
            exp_flags++;
            q.delete();
        end
    endtask

    task automatic model_frame_err(input bit drop);
        exp_errs++;
        if (drop) q.delete();
    endtask

    task automatic model_timeout();
        exp_tos++;
        q.delete();
    endtask

    task automatic drive_bit(input logic v);
        @(negedge sys_clk);
        rx = v;
        repeat (BIT - 1) @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            @(negedge sys_clk);
            rx = 1'b1;
            repeat (n - 1) @(negedge sys_clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1);
        model_byte(b);
    endtask

    task automatic glitch();
        @(negedge sys_clk);
        rx = 1'b0;
        repeat (3) @(negedge sys_clk);
        rx = 1'b1;
        idle(30);
        model_frame_err(1'b0);
    endtask

    task automatic check_all(input string tag);
        idle(20);
        check({tag, ".flags16"}, flag16_cnt, exp_flags);
        check({tag, ".flags12"}, flag12_cnt, exp_flags);
        check({tag, ".errs"},    err16_cnt + err12_cnt, 2 * exp_errs);
        check({tag, ".tos"},     to16_cnt + to12_cnt, 2 * exp_tos);
        check({tag, ".data16"},  po_data16, exp_word);
        check({tag, ".data12"},  po_data12, exp_word & 16'h0FFF);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        repeat (3) @(negedge sys_clk);
        check("rst.data16", po_data16, 16'h0);
        check("rst.data12", po_data12, 12'h0);
        check("rst.outs", {po_flag16, frame_err16, rx_timeout16, po_flag12, frame_err12, rx_timeout12}, 0);
        sys_rst_n = 1'b1;
        idle(20);

        send_good(8'hA5);
        send_good(8'h3C);
        check_all("basic");

        send_good(8'hEF);
        send_good(8'hFD);
        check_all("pad");

        send_good(8'h11);
        send_byte(8'h99, 1'b0);
        model_frame_err(1'b1);
        @(negedge sys_clk);
        rx = 1'b0;
        repeat (29) @(negedge sys_clk);
        idle(30);
        check_all("ferr");
        send_good(8'h22);
        send_good(8'h33);
        check_all("ferr_recover");

        send_good(8'h55);
        idle(20 * BIT + 5);
        model_timeout();
        send_good(8'h66);
        send_good(8'h77);
        check_all("timeout");

        glitch();
        check_all("glitch");

        send_good(8'h5A);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        rx = 1'b1;
        q.delete();
        exp_word = '0;
        @(negedge sys_clk);
        check("midrst.data16", po_data16, 16'h0);
        check("midrst.outs", {po_flag16, frame_err16, rx_timeout16, po_flag12, frame_err12, rx_timeout12}, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(20);
        send_good(8'h01);
        send_good(8'h02);
        check_all("midrst");

        for (int w = 0; w < 25; w++) begin
            if ($urandom_range(0, 3) == 0) glitch();
            for (int k = 0; k < 2; k++) begin
                b = 8'($urandom_range(0, 255));
                send_good(b);
                idle($urandom_range(0, 12));
            end
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
